// File: rtl/rx_sbinit_pkg.sv
// Shared SBINIT definitions: sideband message codes and the SBINIT state encoding.
// The message codes are also used by the transmit-side SBINIT sequencer.
package rx_sbinit_pkg;

    // Sideband message codes exchanged during SBINIT
    localparam int MSG_DONE_REQ     = 1;
    localparam int MSG_DONE_RESP    = 2;
    localparam int MSG_OUT_OF_RESET = 3;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_WAIT_DONE_REQ  = 3'd1,
        ST_SEND_DONE_RESP = 3'd2,
        ST_END            = 3'd3,
        ST_TIMEOUT        = 3'd4
    } sbinit_state_e;

endpackage

// File: rtl/sbinit_timeout_cnt.sv
// Saturating cycle counter for LTSM timeouts. Counts while enabled, holds at
// LIMIT-1 (never wraps) and flags expired while sitting there. clear wins over enable.
module sbinit_timeout_cnt #(
    parameter int LIMIT = 8000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    assign expired = (count == LAST);

    // Count up while enabled, saturating at LAST
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rx_sbinit.sv
// Receive-side SBINIT sequencer: waits for the partner's SBINIT done request,
// answers with done response through the sideband wrapper, then reports
// completion (or timeout) to the LTSM.
//
// Wrapper handshake: o_valid_rx is raised together with o_encoded_SB_msg_rx and
// held until a cycle where i_falling_edge_busy is high while i_tx_valid is low;
// while the transmit-side sequencer owns the wrapper (i_tx_valid high) a busy
// falling edge belongs to it and does not complete our send.
module rx_sbinit
    import rx_sbinit_pkg::*;
#(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_SBINIT_en,
    input  logic                    i_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_tx_valid,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
    output logic                    o_valid_rx,
    output logic                    o_SBINIT_end_rx,
    output logic                    o_timeout
);

    sbinit_state_e           state_q, state_d;
    logic [SB_MSG_WIDTH-1:0] code_d;
    logic                    valid_d, end_d, timeout_d;
    logic                    expired, waiting, timer_clear;
    logic                    done_req, send_done;

    assign done_req  = i_msg_valid && (i_decoded_SB_msg == SB_MSG_WIDTH'(MSG_DONE_REQ));
    assign send_done = o_valid_rx && i_falling_edge_busy && !i_tx_valid;

    // Timer runs only in the two waiting states and restarts on every state change
    assign waiting     = (state_q == ST_WAIT_DONE_REQ) || (state_q == ST_SEND_DONE_RESP);
    assign timer_clear = !waiting || (state_d != state_q);

    sbinit_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (timer_clear),
        .enable  (waiting),
        .expired (expired)
    );

    // Next state and next output values; disable overrides everything
    always_comb begin
        state_d   = state_q;
        valid_d   = o_valid_rx;
        code_d    = o_encoded_SB_msg_rx;
        end_d     = o_SBINIT_end_rx;
        timeout_d = o_timeout;

        if (!i_SBINIT_en) begin
            state_d   = ST_IDLE;
            valid_d   = 1'b0;
            code_d    = '0;
            end_d     = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_WAIT_DONE_REQ;
                    valid_d   = 1'b0;
                    code_d    = '0;
                    end_d     = 1'b0;
                    timeout_d = 1'b0;
                end
                ST_WAIT_DONE_REQ: begin
                    // A done request in the expiry cycle still wins
                    if (done_req) begin
                        state_d = ST_SEND_DONE_RESP;
                        valid_d = 1'b1;
                        code_d  = SB_MSG_WIDTH'(MSG_DONE_RESP);
                    end else if (expired) begin
                        state_d   = ST_TIMEOUT;
                        valid_d   = 1'b0;
                        timeout_d = 1'b1;
                    end
                end
                ST_SEND_DONE_RESP: begin
                    // Completion in the expiry cycle still wins
                    if (send_done) begin
                        state_d = ST_END;
                        valid_d = 1'b0;
                        end_d   = 1'b1;
                    end else if (expired) begin
                        state_d   = ST_TIMEOUT;
                        valid_d   = 1'b0;
                        timeout_d = 1'b1;
                    end
                end
                ST_END: begin
                    end_d = 1'b1;
                    // A repeated done request is answered again without leaving END
                    if (o_valid_rx) begin
                        if (send_done) valid_d = 1'b0;
                    end else if (done_req) begin
                        valid_d = 1'b1;
                        code_d  = SB_MSG_WIDTH'(MSG_DONE_RESP);
                    end
                end
                ST_TIMEOUT: begin
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q             <= ST_IDLE;
            o_valid_rx          <= 1'b0;
            o_encoded_SB_msg_rx <= '0;
            o_SBINIT_end_rx     <= 1'b0;
            o_timeout           <= 1'b0;
        end else begin
            state_q             <= state_d;
            o_valid_rx          <= valid_d;
            o_encoded_SB_msg_rx <= code_d;
            o_SBINIT_end_rx     <= end_d;
            o_timeout           <= timeout_d;
        end
    end

endmodule

// File: doc/rx_sbinit.md
# rx_sbinit

Receive-side SBINIT sequencer for the UCIe sideband link-training state machine. It runs alongside the transmit-side SBINIT sequencer under the same LTSM enable and watches decoded partner messages. When the partner sends SBINIT done request, it answers with SBINIT done response through the shared sideband wrapper. It then reports completion, or a timeout, to the LTSM.

## Interface
- SB_MSG_WIDTH, 4: width of encoded/decoded sideband message codes.
- TIMEOUT_CYCLES, 8000: cycles allowed in the waiting states before a timeout is declared; minimum 2.

- i_clk  input  1  sole clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_SBINIT_en  input  1  LTSM enable; low forces return to IDLE.
- i_msg_valid  input  1  single-cycle strobe: i_decoded_SB_msg holds a newly received partner message.
- i_decoded_SB_msg  input  SB_MSG_WIDTH  decoded partner message code.
- i_falling_edge_busy  input  1  wrapper strobe: current sideband transmission finished.
- i_tx_valid  input  1  valid from the transmit-side SBINIT sequencer.
- o_encoded_SB_msg_rx  output  SB_MSG_WIDTH  message code to encode and send.
- o_valid_rx  output  1  wrapper request: o_encoded_SB_msg_rx is ready to send.
- o_SBINIT_end_rx  output  1  level: done response fully sent.
- o_timeout  output  1  level: sequence timed out.

## Operation
- Message codes: done_req = 1, done_resp = 2, out_of_reset = 3. All other codes are ignored.
- States: IDLE, WAIT_DONE_REQ, SEND_DONE_RESP, END, TIMEOUT.
- IDLE
  - Goes to WAIT_DONE_REQ when i_SBINIT_en is high.
  - Clears all outputs and the timer.
- WAIT_DONE_REQ
  - Goes to SEND_DONE_RESP on i_msg_valid with code 1.
  - out_of_reset (code 3) and other codes are ignored.
- SEND_DONE_RESP
  - On entry, o_encoded_SB_msg_rx is set to 2 and o_valid_rx to 1.
  - o_valid_rx clears on i_falling_edge_busy when i_tx_valid is low. While i_tx_valid is high, o_valid_rx holds.
  - The state goes to END in the same cycle o_valid_rx clears.
- END
  - o_SBINIT_end_rx = 1, held until i_SBINIT_en falls.
  - A repeat done_req in END re-sends done_resp with the same handshake. END is not left, and o_SBINIT_end_rx stays high.
- TIMEOUT
  - o_timeout = 1 and o_valid_rx = 0, held until i_SBINIT_en falls.
- Timer
  - Counts every cycle in WAIT_DONE_REQ and SEND_DONE_RESP, and resets on entry to either state.
  - When the count reaches TIMEOUT_CYCLES-1, the next state is TIMEOUT.
  - Counter width is $clog2(TIMEOUT_CYCLES). It saturates and never wraps.
- i_SBINIT_en low in any state: the next state is IDLE and all outputs clear on the following edge. An in-flight o_valid_rx is dropped.
- Simultaneous events:
  - done_req arriving in the same cycle as the timer expiring: done_req wins.
  - A falling_edge_busy that completes the send, arriving in the same cycle as expiry: the completion wins and the next state is END.

## Timing
- Reset values: o_encoded_SB_msg_rx = 0, o_valid_rx = 0, o_SBINIT_end_rx = 0, o_timeout = 0; state = IDLE; timer = 0.
- All outputs are registered.
- i_SBINIT_en sampled high at edge N: WAIT_DONE_REQ from edge N.
- done_req strobe sampled at edge N: o_valid_rx = 1 and code 2 visible after edge N (one-cycle latency).
- i_falling_edge_busy with i_tx_valid low, sampled at edge M: o_valid_rx = 0 and o_SBINIT_end_rx = 1 after edge M.
- Timeout: o_timeout rises TIMEOUT_CYCLES cycles after entry to WAIT_DONE_REQ if no done_req arrives.
- i_SBINIT_en low sampled at edge K: all outputs are 0 after edge K.

## Structure
- Shared SBINIT package holds:
  - message-code constants (done_req, done_resp, out_of_reset), reused by the transmit-side sequencer;
  - the state encoding.
- One sub-module, sbinit_timeout_cnt: parameterised saturating counter with clear and enable inputs and an expired output. It is reusable by later LTSM states.
- Next-state logic is combinational; state, outputs and timer are sequential in the top module.

## Test plan
- Basic handshake:
  - Stimulus: en = 1; code 3 strobe, then code 1 strobe at cycle 5; busy falling edge at cycle 12 with tx_valid = 0.
  - Required: valid_rx = 1 with code 2 during cycles 6–12; valid_rx = 0 and end_rx = 1 from cycle 13.
- Arbitration:
  - Stimulus: tx_valid = 1 while busy falls at cycle 12; tx_valid = 0 at the next busy fall, cycle 20.
  - Required: valid_rx holds through cycle 20 and clears at cycle 21.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 16; en = 1; no messages.
  - Required: o_timeout = 1 sixteen cycles after entry; valid_rx stays 0.
- Collision at expiry:
  - Stimulus: done_req strobe in the expiry cycle.
  - Required: SEND_DONE_RESP is entered and o_timeout stays 0.
- Abort:
  - Stimulus: en drops while valid_rx = 1.
  - Required: all outputs are 0 next cycle; a later en = 1 restarts cleanly.
- Reset:
  - Stimulus: i_rst held mid-sequence.
  - Required: all outputs 0 and state IDLE after the clocked reset edge.
